// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - core-to-data-memory bus: store strobe, byte address, store and load data
interface dmem_responder_if;
  logic        memwrite;
  logic [31:0] addr;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output memwrite, addr, writedata, input readdata);
  modport slave  (input memwrite, addr, writedata, output readdata);
endinterface

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder: word RAM, post-reset clear sweep, sticky access faults
// Optional MMIO window (cycle counter, store counter, gpio register) built when DMEM_MMIO_EN is defined.
module dmem_responder #(
  parameter int unsigned DEPTH     = 64,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
) (
  input  logic              clk,
  input  logic              reset,
  dmem_responder_if.slave   bus,
  output logic              init_busy,
  output logic              fault_mis,
  output logic              fault_oob,
  output logic [31:0]       gpio_out
);

  localparam int unsigned    AW        = $clog2(DEPTH);
  localparam logic [AW-1:0]  LAST      = AW'(DEPTH - 1);
  localparam logic [31:0]    RAM_BYTES = 32'(4 * DEPTH);
`ifdef DMEM_MMIO_EN
  localparam bit MMIO_EN = 1'b1;
`else
  localparam bit MMIO_EN = 1'b0;
`endif

  typedef enum logic {CLEAR, RUN} state_t;

  state_t         state_q, state_d;
  logic [AW-1:0]  ptr_q, ptr_d;
  logic           fault_mis_q, fault_mis_d;
  logic           fault_oob_q, fault_oob_d;
  logic [31:0]    mem_q [DEPTH];
  logic           mem_we;
  logic [AW-1:0]  mem_idx;
  logic [31:0]    mem_wdata;
  logic [AW-1:0]  idx;
  logic           mis, ram_hit, mmio_hit, run, store;
  logic [31:0]    mmio_rdata;

  assign idx      = bus.addr[AW+1:2];
  assign mis      = bus.addr[1:0] != 2'b00;
  assign ram_hit  = bus.addr < RAM_BYTES;
  assign mmio_hit = MMIO_EN && (bus.addr[31:4] == MMIO_BASE[31:4]);
  assign run      = state_q == RUN;
  assign store    = run && bus.memwrite;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    fault_mis_d = fault_mis_q;
    fault_oob_d = fault_oob_q;
    mem_we      = 1'b0;
    mem_idx     = idx;
    mem_wdata   = bus.writedata;
    case (state_q)
      CLEAR: begin
        // Stores arriving during the sweep are dropped silently.
        mem_we    = 1'b1;
        mem_idx   = ptr_q;
        mem_wdata = '0;
        ptr_d     = ptr_q + 1'b1;
        if (ptr_q == LAST) state_d = RUN;
      end
      RUN: begin
        if (store) begin
          if (mis) fault_mis_d = 1'b1;
          if (!ram_hit && !mmio_hit) fault_oob_d = 1'b1;
          mem_we = !mis && ram_hit;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= CLEAR;
      ptr_q       <= '0;
      fault_mis_q <= 1'b0;
      fault_oob_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      fault_mis_q <= fault_mis_d;
      fault_oob_q <= fault_oob_d;
    end
  end

  // RAM contents survive reset; only the sweep clears them.
  always_ff @(posedge clk) begin
    if (reset && mem_we) mem_q[mem_idx] <= mem_wdata;
  end

  always_comb begin
    bus.readdata = '0;
    if (run) begin
      if (ram_hit)       bus.readdata = mem_q[idx];
      else if (mmio_hit) bus.readdata = mmio_rdata;
    end
  end

`ifdef DMEM_MMIO_EN
  logic [31:0] cycles_q, cycles_d;
  logic [31:0] stores_q, stores_d;
  logic [31:0] gpio_q, gpio_d;

  always_comb begin
    cycles_d   = cycles_q;
    stores_d   = stores_q;
    gpio_d     = gpio_q;
    mmio_rdata = '0;
    if (run) cycles_d = cycles_q + 32'd1;
    if (store && !mis && ram_hit) stores_d = stores_q + 32'd1;
    if (store && !mis && mmio_hit && bus.addr[3:2] == 2'd2) gpio_d = bus.writedata;
    case (bus.addr[3:2])
      2'd0:    mmio_rdata = cycles_q;
      2'd1:    mmio_rdata = stores_q;
      2'd2:    mmio_rdata = gpio_q;
      default: mmio_rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cycles_q <= '0;
      stores_q <= '0;
      gpio_q   <= '0;
    end else begin
      cycles_q <= cycles_d;
      stores_q <= stores_d;
      gpio_q   <= gpio_d;
    end
  end

  assign gpio_out = gpio_q;
`else
  assign mmio_rdata = '0;
  assign gpio_out   = '0;
`endif

  assign init_busy = state_q == CLEAR;
  assign fault_mis = fault_mis_q;
  assign fault_oob = fault_oob_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - scoreboard bench for dmem_responder against an array-based reference model
module tb_dmem_responder;
  localparam int DEPTH = 64;
  localparam int SEL_RD = 0, SEL_BUSY = 1, SEL_MIS = 2, SEL_OOB = 3, SEL_GPIO = 4;
`ifdef DMEM_MMIO_EN
  localparam bit MMIO = 1'b1;
`else
  localparam bit MMIO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        init_busy, fault_mis, fault_oob;
  logic [31:0] gpio_out;

  dmem_responder_if bus();

  dmem_responder #(.DEPTH(DEPTH), .MMIO_BASE(32'hFFFF_0000)) dut (
    .clk(clk), .reset(reset), .bus(bus), .init_busy(init_busy),
    .fault_mis(fault_mis), .fault_oob(fault_oob), .gpio_out(gpio_out)
  );

  always #5 clk = ~clk;

  typedef struct { string name; int sel; logic [31:0] exp; } chk_t;
  chk_t sb[$];
  chk_t e;
  int   total = 0;
  int   bad   = 0;

  logic [31:0] ref_mem [DEPTH];
  bit          ref_run, ref_mis, ref_oob;
  logic [31:0] ref_cycles, ref_stores, ref_gpio;

  function automatic logic [31:0] act(input int sel);
    case (sel)
      SEL_RD:   return bus.readdata;
      SEL_BUSY: return {31'b0, init_busy};
      SEL_MIS:  return {31'b0, fault_mis};
      SEL_OOB:  return {31'b0, fault_oob};
      default:  return gpio_out;
    endcase
  endfunction

  always @(negedge clk) begin
    while (sb.size() > 0) begin
      e = sb.pop_front();
      total++;
      if (act(e.sel) !== e.exp) begin
        bad++;
        $display("FAIL %s: got %h expected %h", e.name, act(e.sel), e.exp);
      end
    end
  end

  function automatic bit in_ram(input logic [31:0] a);
    return a < 32'(4 * DEPTH);
  endfunction

  function automatic bit in_mmio(input logic [31:0] a);
    return MMIO && (a >= 32'hFFFF_0000) && (a <= 32'hFFFF_000F);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (!ref_run) return 32'h0;
    if (in_ram(a)) return ref_mem[(a / 4) % DEPTH];
    if (in_mmio(a)) begin
      case ((a - 32'hFFFF_0000) / 4)
        0:       return ref_cycles;
        1:       return ref_stores;
        2:       return ref_gpio;
        default: return 32'h0;
      endcase
    end
    return 32'h0;
  endfunction

  task automatic model_store(input logic [31:0] a, input logic [31:0] d);
    bit aligned;
    aligned = (a % 4) == 0;
    if (!aligned) ref_mis = 1'b1;
    if (!in_ram(a) && !in_mmio(a)) ref_oob = 1'b1;
    if (aligned && in_ram(a)) begin
      ref_mem[(a / 4) % DEPTH] = d;
      ref_stores++;
    end
    if (aligned && a == 32'hFFFF_0008 && MMIO) ref_gpio = d;
  endtask

  task automatic push(input string n, input int sel, input logic [31:0] exp);
    sb.push_back('{n, sel, exp});
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    if (ref_run) ref_cycles++;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d);
    bus.addr      = a;
    bus.writedata = d;
    bus.memwrite  = 1'b1;
    if (ref_run) model_store(a, d);
    cyc();
    bus.memwrite  = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] a, input string n);
    bus.addr = a;
    push(n, SEL_RD, model_read(a));
    cyc();
  endtask

  task automatic chk_flags(input string n);
    push({n, "_mis"}, SEL_MIS, {31'b0, ref_mis});
    push({n, "_oob"}, SEL_OOB, {31'b0, ref_oob});
    push({n, "_gpio"}, SEL_GPIO, ref_gpio);
  endtask

  task automatic do_reset(input int n);
    reset        = 1'b0;
    bus.memwrite = 1'b0;
    ref_run      = 1'b0;
    ref_mis      = 1'b0;
    ref_oob      = 1'b0;
    ref_cycles   = '0;
    ref_stores   = '0;
    ref_gpio     = '0;
    for (int i = 0; i < n; i++) begin
      cyc();
      push("busy_in_reset", SEL_BUSY, 32'd1);
    end
    chk_flags("reset");
    reset = 1'b1;
  endtask

  task automatic sweep_part(input int n, input bit poke);
    for (int i = 0; i < n; i++) begin
      push("init_busy", SEL_BUSY, 32'd1);
      if (poke && i == 10)      do_load(32'hFC, "clear_read");
      else if (poke && i == 11) do_store(32'h0, 32'h1234_5678);
      else                      cyc();
    end
  endtask

  task automatic full_sweep(input bit poke);
    sweep_part(DEPTH, poke);
    push("init_busy_end", SEL_BUSY, 32'd0);
    ref_run = 1'b1;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
  endtask

  initial begin
    logic [31:0] a;
    reset         = 1'b0;
    bus.memwrite  = 1'b0;
    bus.addr      = '0;
    bus.writedata = '0;
    ref_run       = 1'b0;

    do_reset(2);
    full_sweep(1'b0);

    repeat (24) do_store(32'($urandom_range(0, DEPTH - 1)) * 4, $urandom);
    for (int i = 0; i < DEPTH; i++) do_load(32'(i) * 4, "fill_rd");

    do_store(32'h10, 32'hDEAD_BEEF);
    do_load(32'h10, "rd_0x10");
    do_store(32'hFC, $urandom | 32'h1);
    do_load(32'hFC, "rd_0xFC");
    do_load(32'hF8, "rd_0xF8");
    chk_flags("clean");

    do_store(32'h13, 32'h1111_1111);
    do_load(32'h10, "mis_nowrite");
    chk_flags("after_mis");
    do_load(32'h12, "mis_read");
    do_store(32'h100, 32'h2222_2222);
    chk_flags("after_oob");
    do_load(32'h100, "oob_read");

    repeat (40) begin
      case ($urandom_range(0, 3))
        0:       a = 32'($urandom_range(0, DEPTH - 1)) * 4;
        1:       a = 32'($urandom_range(0, DEPTH - 1)) * 4 + 32'($urandom_range(1, 3));
        2:       a = 32'h100 + 32'($urandom_range(0, 16'hFFFF));
        default: a = 32'hFFFF_0000 + 32'($urandom_range(0, 15));
      endcase
      if ($urandom_range(0, 1) == 1) begin
        do_store(a, $urandom);
        chk_flags("rand_st");
      end else begin
        do_load(a, "rand_ld");
      end
    end

    do_reset(1);
    full_sweep(1'b0);
`ifdef DMEM_MMIO_EN
    do_store(32'hFFFF_0008, 32'hA5);
    chk_flags("gpio_wr");
    repeat (3) do_store(32'($urandom_range(0, DEPTH - 1)) * 4, $urandom);
    do_load(32'hFFFF_0004, "stores_cnt");
    do_load(32'hFFFF_0000, "cycles_a");
    repeat (7) cyc();
    do_load(32'hFFFF_0000, "cycles_b");
    do_store(32'hFFFF_0000, 32'h5);
    chk_flags("ro_wr");
    do_load(32'hFFFF_000C, "mmio_c");
    do_store(32'hFFFF_0009, 32'h77);
    chk_flags("mmio_mis");
`else
    do_store(32'hFFFF_0008, 32'hA5);
    chk_flags("gpio_wr");
    do_load(32'hFFFF_0008, "mmio_rd");
`endif

    for (int i = 0; i < DEPTH; i++) do_store(32'(i) * 4, $urandom | 32'h1);
    do_reset(1);
    sweep_part(30, 1'b0);
    do_reset(1);
    full_sweep(1'b1);
    chk_flags("post_restart");
    for (int i = 0; i < DEPTH; i++) do_load(32'(i) * 4, "post_clear");

    cyc();
    @(negedge clk);
    #1;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: got %0d expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
